snake_game_ctrl: RTL and testbench
==================================

# snake_game_ctrl

Game sequencer for the snake playfield. Owns the game-state FSM, the movement tick, the direction arbiter for the four buttons and wall-collision detection. Issues one-cycle step and load strobes to the snake position datapath and reads the current head position back. All outputs are registered in the `clk` domain.

## Interface
- `TICK_DIV`, 16: clk cycles per movement tick (≥4).
- `X_MAX`, 20: playfield width in cells; valid x is 0..X_MAX-1.
- `Y_MAX`, 30: playfield height in cells; valid y is 0..Y_MAX-1.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `btn_left` / `btn_right` / `btn_up` / `btn_down`  in  1 each  level button inputs, already synchronised.
- `btn_start`  in  1  start/restart request, level.
- `head_x`  in  8  current head x from datapath.
- `head_y`  in  8  current head y from datapath.
- `load_start`  out  1  one-cycle pulse; datapath reloads the start position.
- `step`  out  1  one-cycle pulse; datapath moves head one cell in `dir`.
- `dir`  out  2  0=LEFT, 1=RIGHT, 2=UP, 3=DOWN; stable whenever `step`=1.
- `running`  out  1  high in RUN, DECIDE and EVAL.
- `game_over`  out  1  high in OVER.
- `score`  out  8  successful steps since last load; saturates at 255.

## Operation
- States: IDLE, LOAD, RUN, DECIDE, EVAL, OVER.
- Reset values: state IDLE; `dir`=LEFT; `score`=0; `step`=`load_start`=`running`=`game_over`=0; tick counter=0; pending presses=0.
- IDLE: `btn_start`=1 moves to LOAD.
- LOAD, one cycle:
  - `load_start`=1.
  - `score`←0, `dir`←LEFT, counter←0, pending←0.
  - Next state RUN.
- RUN:
  - Counter increments each cycle. Any button high sets its pending bit, which is sticky.
  - When counter==TICK_DIV-1: counter←0, go to DECIDE.
- DECIDE, one cycle:
  - `dir`← arbitration result. Pending bits are cleared.
  - A button high during DECIDE sets its pending bit after the clear, so it is kept for the next tick.
- Arbitration:
  - Candidates are the pending bits minus the reverse of the current `dir` (LEFT↔RIGHT, UP↔DOWN).
  - Priority LEFT > RIGHT > UP > DOWN among candidates.
  - No candidate: `dir` unchanged.
- EVAL, one cycle:
  - Wall hit is any of: LEFT with `head_x`==0; RIGHT with `head_x`==X_MAX-1; UP with `head_y`==0; DOWN with `head_y`==Y_MAX-1.
  - Wall hit → OVER, no step.
  - Otherwise `step`=1, `score`←min(score+1, 255), back to RUN.
  - Buttons keep latching in EVAL.
- OVER: `game_over`=1 and `score` holds. `btn_start`=1 moves to LOAD.
- `btn_start` is ignored in LOAD, RUN, DECIDE and EVAL.
- Out-of-range `head_x`/`head_y` (≥ bound) is not corrected here; boundary compares are equality only.

## Timing
- Counter reaches TICK_DIV-1 in cycle T. DECIDE is T+1. EVAL is T+2, with `step` or the OVER transition. RUN resumes at T+3 with counter=0 on entry.
- Step period is therefore TICK_DIV+2 cycles.
- `dir` changes only on the DECIDE→EVAL edge, or to LEFT in LOAD.
- `head_x`/`head_y` are sampled in EVAL. The datapath updates the head the cycle after `step`, before the next EVAL.
- `btn_start` high in IDLE at cycle C gives `load_start`=1 at C+1 and RUN from C+2. A held start causes no re-load while running.
- `reset` wins over every transition. Asserting it in any state returns to IDLE next edge with the reset values; strobes already issued are not repeated.

## Structure
- Package `snake_pkg` holds:
  - the direction encoding (`DIR_LEFT`..`DIR_DOWN`);
  - the state enum;
  - default `X_MAX`/`Y_MAX`/start coordinates, shared with the position datapath and the renderer.
- Sub-module `snake_dir_arbiter` holds the four pending latches, the clear-with-set-priority rule and the reversal/priority logic. Its interface is clear, current dir in, arbitrated dir out.
- The top contains the FSM, tick counter, collision compare and score.

## Test plan
- Bench runs with TICK_DIV=4 unless noted.
1. Reset, then `btn_start` pulse, no buttons, head at (10,15) moving per `step` → `load_start` once, then `step` every 6 cycles with `dir`=0; `score` 1,2,3…
2. Press `btn_up` for one RUN cycle while `dir`=LEFT → next `step` carries `dir`=2. A later `btn_down` alone → rejected, `dir` stays 2.
3. `btn_right` and `btn_up` pressed together while `dir`=LEFT → RIGHT rejected as reverse, `dir`=UP. With `dir`=UP and left+down pressed → `dir`=LEFT.
4. `head_x`=0, `dir`=LEFT at EVAL → no `step`, `game_over`=1 next cycle, `score` frozen. Same check at `head_y`=29 with DOWN (Y_MAX=30).
5. In OVER, pulse `btn_start` → `load_start`=1, `score`=0, `dir`=0, `running`=1. Then assert `reset` for one cycle mid-RUN → all outputs at reset values and state IDLE.
6. Button asserted only in the DECIDE cycle → applied at the following tick, not lost. With TICK_DIV=4 and 300 steps, `score` saturates at 255.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction codes, sequencer states
// and default playfield geometry used by the controller, datapath and renderer.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_LEFT  = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_UP    = 2'd2;
  localparam dir_t DIR_DOWN  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DECIDE,
    ST_EVAL,
    ST_OVER
  } state_t;

  localparam int DEF_TICK_DIV = 16;
  localparam int DEF_X_MAX    = 20;
  localparam int DEF_Y_MAX    = 30;

  localparam logic [7:0] START_X = 8'd10;
  localparam logic [7:0] START_Y = 8'd15;

  // Codes are paired so that flipping bit 0 yields the opposite heading.
  function automatic dir_t dir_reverse(input dir_t d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/snake_dir_arbiter.sv
// Sticky button latches plus the direction arbiter: drops the reversal of the
// current heading and picks LEFT > RIGHT > UP > DOWN among the rest.
module snake_dir_arbiter
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_btn,      // indexed by direction code
  input  logic       i_clear,
  input  logic       i_latch,
  input  dir_t       i_cur_dir,
  output dir_t       o_arb_dir
);

  logic [3:0] r_pending;
  logic [3:0] w_pending_next;
  logic [3:0] w_cand;

  // A press in the clearing cycle survives the clear so it is not lost.
  always_comb begin
    w_pending_next = r_pending;
    if (i_clear) w_pending_next = 4'b0000;
    if (i_latch) w_pending_next = w_pending_next | i_btn;
  end

  always_ff @(posedge clk) begin
    if (reset) r_pending <= 4'b0000;
    else       r_pending <= w_pending_next;
  end

  always_comb begin
    w_cand = r_pending;
    w_cand[dir_reverse(i_cur_dir)] = 1'b0;
    if      (w_cand[DIR_LEFT])  o_arb_dir = DIR_LEFT;
    else if (w_cand[DIR_RIGHT]) o_arb_dir = DIR_RIGHT;
    else if (w_cand[DIR_UP])    o_arb_dir = DIR_UP;
    else if (w_cand[DIR_DOWN])  o_arb_dir = DIR_DOWN;
    else                        o_arb_dir = i_cur_dir;
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game-state FSM, movement tick, wall collision and score.
// Decisions made in a state appear on the registered outputs the following cycle.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int X_MAX    = DEF_X_MAX,
  parameter int Y_MAX    = DEF_Y_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic [7:0] head_x,
  input  logic [7:0] head_y,
  output logic       load_start,
  output logic       step,
  output logic [1:0] dir,
  output logic       running,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int              CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0]      X_LAST   = 8'(X_MAX - 1);
  localparam logic [7:0]      Y_LAST   = 8'(Y_MAX - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  dir_t          r_dir;
  dir_t          w_arb_dir;
  logic [7:0]    r_score;
  logic          r_step;
  logic          r_load;
  logic          r_running;
  logic          r_over;
  logic          w_wall;
  logic          w_clear;
  logic          w_latch;

  snake_dir_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_btn     ({btn_down, btn_up, btn_right, btn_left}),
    .i_clear   (w_clear),
    .i_latch   (w_latch),
    .i_cur_dir (r_dir),
    .o_arb_dir (w_arb_dir)
  );

  // Equality only: an out-of-range head never counts as a wall.
  always_comb begin
    w_wall = 1'b0;
    case (r_dir)
      DIR_LEFT:  w_wall = (head_x == 8'd0);
      DIR_RIGHT: w_wall = (head_x == X_LAST);
      DIR_UP:    w_wall = (head_y == 8'd0);
      DIR_DOWN:  w_wall = (head_y == Y_LAST);
      default:   w_wall = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      ST_IDLE:   if (btn_start) w_state_next = ST_LOAD;
      ST_LOAD: begin
        w_clear      = 1'b1;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_latch = 1'b1;
        if (r_cnt == CNT_LAST) w_state_next = ST_DECIDE;
      end
      ST_DECIDE: begin
        w_clear      = 1'b1;
        w_latch      = 1'b1;
        w_state_next = ST_EVAL;
      end
      ST_EVAL: begin
        w_latch      = 1'b1;
        w_state_next = w_wall ? ST_OVER : ST_RUN;
      end
      ST_OVER:   if (btn_start) w_state_next = ST_LOAD;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_dir     <= DIR_LEFT;
      r_score   <= 8'd0;
      r_step    <= 1'b0;
      r_load    <= 1'b0;
      r_running <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_load    <= (w_state_next == ST_LOAD);
      r_running <= (w_state_next == ST_RUN) || (w_state_next == ST_DECIDE) ||
                   (w_state_next == ST_EVAL);
      r_over    <= (w_state_next == ST_OVER);
      r_step    <= (r_state == ST_EVAL) && !w_wall;
      case (r_state)
        ST_LOAD: begin
          r_score <= 8'd0;
          r_dir   <= DIR_LEFT;
          r_cnt   <= '0;
        end
        ST_RUN:    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
        ST_DECIDE: r_dir <= w_arb_dir;
        ST_EVAL:   if (!w_wall && r_score != 8'd255) r_score <= r_score + 8'd1;
        default: ;
      endcase
    end
  end

  assign load_start = r_load;
  assign step       = r_step;
  assign dir        = r_dir;
  assign running    = r_running;
  assign game_over  = r_over;
  assign score      = r_score;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: directed scenarios with literal
// expectations, then random play checked every cycle against a phase-based model.
module tb_snake_game_ctrl;

  localparam int TD = 4;
  localparam int XM = 20;
  localparam int YM = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       btn_start = 1'b0;
  logic [7:0] head_x = 8'd10, head_y = 8'd15;
  logic       load_start, step, running, game_over;
  logic [1:0] dir;
  logic [7:0] score;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit dp_freeze = 1'b0;
  logic [7:0] start_x = 8'd10, start_y = 8'd15;

  snake_game_ctrl #(.TICK_DIV(TD), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clk(clk), .reset(reset),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .btn_start(btn_start), .head_x(head_x), .head_y(head_y),
    .load_start(load_start), .step(step), .dir(dir),
    .running(running), .game_over(game_over), .score(score)
  );

  always #5 clk = ~clk;

  // Reference model: game mode plus a cycle count since play began; the
  // position inside each movement period is plain modular arithmetic.
  localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_OVER = 3;
  int         m_mode = M_IDLE;
  int         m_t = 0;
  int         m_dir = 0;
  int         m_score = 0;
  logic [3:0] m_pend = 4'b0;
  logic       exp_load = 1'b0, exp_step = 1'b0, exp_run = 1'b0, exp_over = 1'b0;
  logic [1:0] exp_dir = 2'd0;
  logic [7:0] exp_score = 8'd0;

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int arbitrate(input logic [3:0] p, input int cur);
    for (int k = 0; k < 4; k++)
      if (p[k] && k != opposite(cur)) return k;
    return cur;
  endfunction

  function automatic bit hits_wall(input int d, input int x, input int y);
    case (d)
      0: return x == 0;
      1: return x == XM - 1;
      2: return y == 0;
      default: return y == YM - 1;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0] b;
    int         ph;
    logic       stp;
    b   = {btn_down, btn_up, btn_right, btn_left};
    stp = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_t = 0; m_dir = 0; m_score = 0; m_pend = 4'b0;
    end else begin
      case (m_mode)
        M_IDLE, M_OVER: if (btn_start) m_mode = M_LOAD;
        M_LOAD: begin
          m_mode = M_PLAY; m_t = 0; m_dir = 0; m_score = 0; m_pend = 4'b0;
        end
        default: begin
          ph = m_t % (TD + 2);
          if (ph < TD) m_pend = m_pend | b;
          else if (ph == TD) begin
            m_dir  = arbitrate(m_pend, m_dir);
            m_pend = b;
          end else begin
            m_pend = m_pend | b;
            if (hits_wall(m_dir, int'(head_x), int'(head_y))) m_mode = M_OVER;
            else begin
              stp = 1'b1;
              if (m_score < 255) m_score = m_score + 1;
            end
          end
          m_t = m_t + 1;
        end
      endcase
    end
    exp_load  <= (m_mode == M_LOAD);
    exp_run   <= (m_mode == M_PLAY);
    exp_over  <= (m_mode == M_OVER);
    exp_step  <= stp;
    exp_dir   <= 2'(m_dir);
    exp_score <= 8'(m_score);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if ({load_start, step, dir, running, game_over, score} !==
          {exp_load, exp_step, exp_dir, exp_run, exp_over, exp_score}) begin
        n_fail++;
        $display("FAIL cycle_check @%0t: got load=%0b step=%0b dir=%0d run=%0b over=%0b score=%0d, expected load=%0b step=%0b dir=%0d run=%0b over=%0b score=%0d",
                 $time, load_start, step, dir, running, game_over, score,
                 exp_load, exp_step, exp_dir, exp_run, exp_over, exp_score);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; also emulates the position datapath reacting to strobes.
  task automatic cyc();
    @(negedge clk);
    if (load_start) begin
      head_x = start_x;
      head_y = start_y;
    end else if (step && !dp_freeze) begin
      case (dir)
        2'd0: head_x = head_x - 8'd1;
        2'd1: head_x = head_x + 8'd1;
        2'd2: head_y = head_y - 8'd1;
        default: head_y = head_y + 8'd1;
      endcase
    end
  endtask

  task automatic wait_step(input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n < limit);
  endtask

  task automatic wait_over(input int limit, output int n, output bit saw_step);
    n = 0;
    saw_step = 1'b0;
    do begin
      cyc();
      n++;
      if (step) saw_step = 1'b1;
    end while (!game_over && n < limit);
  endtask

  task automatic pulse_start();
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  loads;
    bit  saw;

    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    check("reset_dir", int'(dir), 0);
    check("reset_score", int'(score), 0);
    check("reset_flags", int'({load_start, step, running, game_over}), 0);

    // 1: straight run left from the start cell
    pulse_start();
    check("t1_load", int'(load_start), 1);
    wait_step(12, n);
    check("t1_first_step_latency", n, 7);
    check("t1_score1", int'(score), 1);
    wait_step(12, n);
    check("t1_step_period", n, 6);
    wait_step(12, n);
    check("t1_score3", int'(score), 3);
    check("t1_dir_left", int'(dir), 0);

    // 2: perpendicular turn accepted, reversal rejected
    btn_up = 1'b1; cyc(); btn_up = 1'b0;
    wait_step(12, n);
    check("t2_turn_latency", n, 5);
    check("t2_dir_up", int'(dir), 2);
    btn_down = 1'b1; cyc(); btn_down = 1'b0;
    wait_step(12, n);
    check("t2_reverse_rejected", int'(dir), 2);

    // 3: priority and reversal together
    btn_left = 1'b1; cyc(); btn_left = 1'b0;
    wait_step(12, n);
    check("t3_back_left", int'(dir), 0);
    btn_right = 1'b1; btn_up = 1'b1; cyc(); btn_right = 1'b0; btn_up = 1'b0;
    wait_step(12, n);
    check("t3_right_up_gives_up", int'(dir), 2);
    btn_left = 1'b1; btn_down = 1'b1; cyc(); btn_left = 1'b0; btn_down = 1'b0;
    wait_step(12, n);
    check("t3_left_down_gives_left", int'(dir), 0);

    // 4a: run into the left wall from x=5
    repeat (5) wait_step(12, n);
    check("t4_score_before_wall", int'(score), 13);
    wait_over(12, n, saw);
    check("t4_over_latency", n, 6);
    check("t4_no_step_at_wall", int'(saw), 0);
    repeat (3) cyc();
    check("t4_score_frozen", int'(score), 13);
    check("t4_game_over_held", int'(game_over), 1);

    // 4b: bottom wall with DOWN
    start_y = 8'd28;
    pulse_start();
    check("t4b_load", int'(load_start), 1);
    cyc();
    btn_down = 1'b1; cyc(); btn_down = 1'b0;
    wait_step(12, n);
    check("t4b_dir_down", int'(dir), 3);
    wait_over(12, n, saw);
    check("t4b_no_step_at_wall", int'(saw), 0);
    check("t4b_score", int'(score), 1);
    start_y = 8'd15;

    // 5: restart from OVER, then reset mid-run
    pulse_start();
    check("t5_load", int'(load_start), 1);
    check("t5_over_cleared", int'(game_over), 0);
    cyc();
    check("t5_score0", int'(score), 0);
    check("t5_dir0", int'(dir), 0);
    check("t5_running", int'(running), 1);
    cyc(); cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    check("t5_reset_flags", int'({load_start, step, running, game_over}), 0);
    check("t5_reset_dir_score", int'({dir, score}), 0);
    repeat (10) cyc();
    check("t5_idle_stays", int'(running), 0);

    // 6: held start loads once; DECIDE-only press applies next tick; saturation
    dp_freeze = 1'b1;
    btn_start = 1'b1;
    cyc();
    loads = int'(load_start);
    repeat (5) begin
      cyc();
      loads += int'(load_start);
    end
    btn_up = 1'b1; cyc(); btn_up = 1'b0;
    loads += int'(load_start);
    btn_start = 1'b0;
    check("t6_single_load", loads, 1);
    wait_step(12, n);
    check("t6_decide_press_latency", n, 1);
    check("t6_not_yet_applied", int'(dir), 0);
    wait_step(12, n);
    check("t6_applied_next_tick", int'(dir), 2);
    repeat (300) wait_step(12, n);
    check("t6_score_saturated", int'(score), 255);

    // random play against the model
    dp_freeze = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      btn_left  = ($urandom_range(0, 5) == 0);
      btn_right = ($urandom_range(0, 5) == 0);
      btn_up    = ($urandom_range(0, 5) == 0);
      btn_down  = ($urandom_range(0, 5) == 0);
      btn_start = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 399) == 0);
      start_x   = 8'($urandom_range(0, XM - 1));
      start_y   = 8'($urandom_range(0, YM - 1));
      cyc();
    end
    reset = 1'b0;
    {btn_left, btn_right, btn_up, btn_down, btn_start} = 5'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
